// File: rtl/tx_burst_gate.sv
// rtl/tx_burst_gate.sv - gates free-running PWM into N whole pulses per channel, then times blank and listen windows
module tx_burst_gate #(
    parameter int NUM_CHANNELS           = 4,
    parameter int PERIOD_IN_CLOCK_CYCLES = 2500,
    parameter int BLANK_CYCLES           = 50000,
    parameter int LISTEN_CYCLES          = 3000000
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    trigger_in,
    input  logic [7:0]              num_pulses_in,
    input  logic [NUM_CHANNELS-1:0] pwm_in,
    output logic [NUM_CHANNELS-1:0] tx_out,
    output logic                    burst_start_out,
    output logic                    listen_out,
    output logic                    busy_out,
    output logic                    done_out,
    output logic [NUM_CHANNELS-1:0] fault_out
);

    localparam int TO_CYCLES = 2 * PERIOD_IN_CLOCK_CYCLES;
    localparam int TW        = $clog2(TO_CYCLES + 1);
    localparam int WIN_MAX   = (BLANK_CYCLES > LISTEN_CYCLES) ? BLANK_CYCLES : LISTEN_CYCLES;
    localparam int CW        = $clog2(WIN_MAX + 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TO_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST  = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CW-1:0] LISTEN_LAST = CW'(LISTEN_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_TX, S_BLANK, S_LISTEN} state_e;
    typedef enum logic [1:0] {C_WAIT, C_ACTIVE, C_DONE} ch_state_e;

    state_e                  state_q, state_d;
    ch_state_e               ch_state_q [NUM_CHANNELS];
    ch_state_e               ch_state_d [NUM_CHANNELS];
    logic [7:0]              pulse_cnt_q [NUM_CHANNELS];
    logic [7:0]              pulse_cnt_d [NUM_CHANNELS];
    logic [7:0]              num_q, num_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [CW-1:0]           win_cnt_q, win_cnt_d;
    logic [NUM_CHANNELS-1:0] pwm_dly_q, pwm_dly_d;
    logic [NUM_CHANNELS-1:0] tx_q, tx_d;
    logic [NUM_CHANNELS-1:0] fault_q, fault_d;
    logic                    burst_start_q, burst_start_d;
    logic                    done_q, done_d;
    logic [NUM_CHANNELS-1:0] rise, fall;
    logic                    all_done;

    always_comb begin
        state_d       = state_q;
        ch_state_d    = ch_state_q;
        pulse_cnt_d   = pulse_cnt_q;
        num_d         = num_q;
        timer_d       = timer_q;
        win_cnt_d     = win_cnt_q;
        fault_d       = fault_q;
        pwm_dly_d     = pwm_in;
        tx_d          = '0;
        burst_start_d = 1'b0;
        done_d        = 1'b0;
        rise          = pwm_in & ~pwm_dly_q;
        fall          = ~pwm_in & pwm_dly_q;
        all_done      = 1'b1;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (ch_state_q[i] != C_DONE) all_done = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (trigger_in && num_pulses_in != 8'd0) begin
                    state_d       = S_TX;
                    num_d         = num_pulses_in;
                    fault_d       = '0;
                    timer_d       = '0;
                    burst_start_d = 1'b1;
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        ch_state_d[i]  = C_WAIT;
                        pulse_cnt_d[i] = 8'd0;
                    end
                end
            end
            S_TX: begin
                if (timer_q != TO_LAST) timer_d = timer_q + 1'b1;
                // Only rising edges open a channel, so a pulse already in progress at entry is never cut.
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    case (ch_state_q[i])
                        C_WAIT: begin
                            if (rise[i]) begin
                                ch_state_d[i]  = C_ACTIVE;
                                pulse_cnt_d[i] = 8'd1;
                                tx_d[i]        = pwm_in[i];
                            end else if (timer_q == TO_LAST) begin
                                ch_state_d[i] = C_DONE;
                                fault_d[i]    = 1'b1;
                            end
                        end
                        C_ACTIVE: begin
                            tx_d[i] = pwm_in[i];
                            if (rise[i]) begin
                                pulse_cnt_d[i] = pulse_cnt_q[i] + 8'd1;
                            end else if (fall[i] && pulse_cnt_q[i] == num_q) begin
                                ch_state_d[i] = C_DONE;
                            end
                        end
                        default: ;
                    endcase
                end
                if (all_done) begin
                    state_d   = (BLANK_CYCLES == 0) ? S_LISTEN : S_BLANK;
                    win_cnt_d = '0;
                end
            end
            S_BLANK: begin
                if (win_cnt_q == BLANK_LAST) begin
                    state_d   = S_LISTEN;
                    win_cnt_d = '0;
                end else begin
                    win_cnt_d = win_cnt_q + 1'b1;
                end
            end
            S_LISTEN: begin
                if (win_cnt_q == LISTEN_LAST) begin
                    state_d   = S_IDLE;
                    win_cnt_d = '0;
                    done_d    = 1'b1;
                end else begin
                    win_cnt_d = win_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= S_IDLE;
            num_q         <= '0;
            timer_q       <= '0;
            win_cnt_q     <= '0;
            pwm_dly_q     <= '0;
            tx_q          <= '0;
            fault_q       <= '0;
            burst_start_q <= 1'b0;
            done_q        <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                ch_state_q[i]  <= C_WAIT;
                pulse_cnt_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            num_q         <= num_d;
            timer_q       <= timer_d;
            win_cnt_q     <= win_cnt_d;
            pwm_dly_q     <= pwm_dly_d;
            tx_q          <= tx_d;
            fault_q       <= fault_d;
            burst_start_q <= burst_start_d;
            done_q        <= done_d;
            ch_state_q    <= ch_state_d;
            pulse_cnt_q   <= pulse_cnt_d;
        end
    end

    assign tx_out          = tx_q;
    assign burst_start_out = burst_start_q;
    assign listen_out      = (state_q == S_LISTEN);
    assign busy_out        = (state_q != S_IDLE);
    assign done_out        = done_q;
    assign fault_out       = fault_q;

endmodule

// File: tb/tb_tx_burst_gate.sv
// tb/tb_tx_burst_gate.sv - table-driven bench with burst scoreboard for tx_burst_gate
module tb_tx_burst_gate;

    localparam int NCH    = 4;
    localparam int PER    = 20;
    localparam int HI     = 10;
    localparam int BLANK  = 8;
    localparam int LISTEN = 30;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           trigger;
    logic [7:0]     num_pulses;
    logic [NCH-1:0] pwm;
    logic [NCH-1:0] tx;
    logic [NCH-1:0] fault;
    logic           bs, listen, busy, done;

    tx_burst_gate #(
        .NUM_CHANNELS(NCH),
        .PERIOD_IN_CLOCK_CYCLES(PER),
        .BLANK_CYCLES(BLANK),
        .LISTEN_CYCLES(LISTEN)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .trigger_in(trigger),
        .num_pulses_in(num_pulses),
        .pwm_in(pwm),
        .tx_out(tx),
        .burst_start_out(bs),
        .listen_out(listen),
        .busy_out(busy),
        .done_out(done),
        .fault_out(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0][4:0] off;
        logic [NCH-1:0]      en;
        logic [7:0]          n;
        int                  phase;
        bit                  retrig;
        logic [NCH-1:0][7:0] exp_pulses;
        logic [NCH-1:0]      exp_fault;
    } vec_t;

    typedef struct {
        logic [NCH-1:0][7:0] pulses;
        logic [NCH-1:0]      fault;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[7];

    int total = 0;
    int bad   = 0;
    int tc    = 0;
    int cyc   = 0;

    logic [NCH-1:0][4:0] cfg_off = '0;
    logic [NCH-1:0]      cfg_en  = '0;
    logic [NCH-1:0]      pwm_prev = '0;
    logic [NCH-1:0]      tx_prev  = '0;
    logic                listen_prev = 1'b0;
    logic                done_prev   = 1'b0;

    int rises[NCH];
    int runlen[NCH];
    int badw, lagerr, bs_cnt, done_cnt, listen_len, listen_start, last_tx_cyc, busy_cyc, tx_cyc;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [NCH*5-1:0] off, input logic [NCH-1:0] en,
                                input logic [7:0] n, input int phase, input bit retrig,
                                input logic [NCH*8-1:0] exp_p, input logic [NCH-1:0] exp_f);
        vec_t v;
        v.off        = off;
        v.en         = en;
        v.n          = n;
        v.phase      = phase;
        v.retrig     = retrig;
        v.exp_pulses = exp_p;
        v.exp_fault  = exp_f;
        return v;
    endfunction

    task automatic clear_stats();
        for (int i = 0; i < NCH; i++) begin
            rises[i]  = 0;
            runlen[i] = 0;
        end
        badw = 0; lagerr = 0; bs_cnt = 0; done_cnt = 0; listen_len = 0;
        listen_start = 0; last_tx_cyc = 0; busy_cyc = 0; tx_cyc = 0;
    endtask

    task automatic monitor();
        sb_t e;
        cyc++;
        if (done_prev) check("done_width", int'(done), 0);
        for (int i = 0; i < NCH; i++) begin
            if (tx[i] && !pwm_prev[i]) lagerr++;
            if (tx[i] && !tx_prev[i]) begin
                rises[i]++;
                runlen[i] = 1;
            end else if (tx[i]) begin
                runlen[i]++;
            end else if (tx_prev[i] && runlen[i] != HI) begin
                badw++;
            end
        end
        if (tx != '0) begin
            last_tx_cyc = cyc;
            tx_cyc++;
        end
        if (busy) busy_cyc++;
        if (bs) begin
            bs_cnt++;
            check("fault_clear_at_start", int'(fault), 0);
        end
        if (listen && !listen_prev) listen_start = cyc;
        if (listen) listen_len++;
        if (done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("sb_underflow", 0, 1);
            end else begin
                e = sb_q.pop_front();
                for (int i = 0; i < NCH; i++)
                    check($sformatf("pulses_ch%0d", i), rises[i], int'(e.pulses[i]));
                check("fault", int'(fault), int'(e.fault));
                check("width_err", badw, 0);
                check("lag_err", lagerr, 0);
                check("listen_len", listen_len, LISTEN);
                check("blank_gap", listen_start - last_tx_cyc - 1, BLANK + 1);
                check("burst_starts", bs_cnt, 1);
            end
        end
        pwm_prev    = pwm;
        tx_prev     = tx;
        listen_prev = listen;
        done_prev   = done;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        tc++;
        for (int i = 0; i < NCH; i++)
            pwm[i] = cfg_en[i] && (((((tc - int'(cfg_off[i])) % PER) + PER) % PER) < HI);
        @(negedge clk);
        monitor();
    endtask

    task automatic run_vec(input vec_t v);
        sb_t e;
        int  k;
        cfg_off = v.off;
        cfg_en  = v.en;
        if (v.phase < 0) begin
            step();
        end else begin
            k = 0;
            while ((k < PER || (tc % PER) != v.phase) && k < 3 * PER) begin
                step();
                k++;
            end
        end
        clear_stats();
        e.pulses = v.exp_pulses;
        e.fault  = v.exp_fault;
        sb_q.push_back(e);
        trigger    = 1'b1;
        num_pulses = v.n;
        step();
        trigger    = 1'b0;
        num_pulses = 8'($urandom);
        check("bs_latency", bs_cnt, 1);
        k = 0;
        while (done_cnt == 0 && k < 8000) begin
            step();
            k++;
            num_pulses = 8'($urandom);
            trigger = v.retrig && (k % 7 == 3) && busy && (!listen || listen_len < 20);
        end
        trigger = 1'b0;
        check("done_seen", int'(done_cnt != 0), 1);
    endtask

    task automatic test_zero_n();
        repeat (PER) step();
        clear_stats();
        trigger    = 1'b1;
        num_pulses = 8'd0;
        step();
        step();
        trigger = 1'b0;
        repeat (40) step();
        check("n0_busy", busy_cyc, 0);
        check("n0_burst_start", bs_cnt, 0);
        check("n0_tx", tx_cyc, 0);
    endtask

    task automatic test_reset();
        int k;
        cfg_off = {5'd15, 5'd10, 5'd5, 5'd0};
        cfg_en  = '1;
        repeat (PER) step();
        clear_stats();
        trigger    = 1'b1;
        num_pulses = 8'd3;
        step();
        trigger = 1'b0;
        k = 0;
        while (tx == '0 && k < 3 * PER) begin
            step();
            k++;
        end
        step();
        step();
        check("tx_high_before_rst", int'(tx != '0), 1);
        rst_n = 1'b0;
        #1;
        check("rst_tx", int'(tx), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_listen", int'(listen), 0);
        check("rst_burst_start", int'(bs), 0);
        check("rst_done", int'(done), 0);
        check("rst_fault", int'(fault), 0);
        repeat (3) step();
        rst_n = 1'b1;
        clear_stats();
        repeat (60) step();
        check("post_rst_busy", busy_cyc, 0);
        check("post_rst_done", done_cnt, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        trigger    = 1'b0;
        num_pulses = 8'd0;
        pwm        = '0;
        clear_stats();

        vecs[0] = mk({5'd0, 5'd0, 5'd0, 5'd0},    4'hF,    8'd3,   3,  1'b0, {4{8'd3}},   4'b0000);
        vecs[1] = mk({5'd15, 5'd10, 5'd5, 5'd0},  4'hF,    8'd2,   7,  1'b0, {4{8'd2}},   4'b0000);
        vecs[2] = mk({5'd15, 5'd10, 5'd5, 5'd0},  4'hF,    8'd1,   12, 1'b1, {4{8'd1}},   4'b0000);
        vecs[3] = mk({5'd15, 5'd10, 5'd5, 5'd0},  4'hF,    8'd2,   -1, 1'b0, {4{8'd2}},   4'b0000);
        vecs[4] = mk({5'd15, 5'd10, 5'd5, 5'd0},  4'b1011, 8'd3,   0,  1'b0,
                     {8'd3, 8'd0, 8'd3, 8'd3}, 4'b0100);
        vecs[5] = mk({5'd18, 5'd13, 5'd8, 5'd3},  4'hF,    8'd2,   9,  1'b0, {4{8'd2}},   4'b0000);
        vecs[6] = mk({5'd3, 5'd2, 5'd1, 5'd0},    4'hF,    8'd255, 5,  1'b0, {4{8'd255}}, 4'b0000);

        repeat (3) step();
        check("reset_tx", int'(tx), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_fault", int'(fault), 0);
        check("reset_listen", int'(listen), 0);
        check("reset_burst_start", int'(bs), 0);
        check("reset_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (PER) step();

        for (int v = 0; v < 7; v++) run_vec(vecs[v]);

        test_zero_n();
        test_reset();
        run_vec(vecs[0]);
        check("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
